seq_alu: RTL

- Parametrised, registered successor to the team's 16-bit combinational ALU.
- Same opcode map, SZCV flags and I/O/halt decode, plus an iterative shift-add multiplier.
- Valid/ready handshakes on both sides so the execute stage can stall around multi-cycle ops.
- Sits between register read and writeback in the CPU datapath.

---
 rtl/seq_alu_pkg.sv | 32 +++
 rtl/seq_alu_shifter.sv | 36 +++
 rtl/seq_alu.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode map, FSM states and flag bundle shared by the sequential ALU.
package seq_alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_CMP  = 4'b0101,
      OP_MOV  = 4'b0110,
      OP_MUL  = 4'b0111,
      OP_SLL  = 4'b1000,
      OP_SLR  = 4'b1001,
      OP_SRL  = 4'b1010,
      OP_SRA  = 4'b1011,
      OP_IN   = 4'b1100,
      OP_OUT  = 4'b1101,
      OP_NOP  = 4'b1110,
      OP_HALT = 4'b1111
   } op_t;

   typedef enum logic {IDLE, MUL} state_t;

   typedef struct packed {
      logic s;
      logic z;
      logic c;
      logic v;
   } flag_t;

endpackage

// File: rtl/seq_alu_shifter.sv
// seq_alu_shifter: log-stage shifter for SLL/SLR/SRL/SRA with carry-out of the last bit shifted out.
module seq_alu_shifter
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   localparam int SHW = $clog2(WIDTH)
) (
   input  op_t              op,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   d,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   logic left, rot, arith;
   logic [WIDTH:0] st [SHW+1];

   assign left  = op == OP_SLL;
   assign rot   = op == OP_SLR;
   assign arith = op == OP_SRA;

   // A guard bit travels with the data (above it for left, below it for right) and ends up as the carry.
   assign st[0] = (left || rot) ? {1'b0, b} : {b, 1'b0};

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int N = 1 << k;
      assign st[k+1] = !d[k] ? st[k] :
                       left  ? {st[k][WIDTH-N:0], {N{1'b0}}} :
                       rot   ? {1'b0, st[k][WIDTH-1-N:0], st[k][WIDTH-1:WIDTH-N]} :
                               {{N{arith && st[k][WIDTH]}}, st[k][WIDTH:N]};
   end

   assign result = (left || rot) ? st[SHW][WIDTH-1:0] : st[SHW][WIDTH:1];
   assign carry  = (left || rot) ? st[SHW][WIDTH] : st[SHW][0];

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes and SZCV flags.
// Define SEQ_ALU_MUL_EN to build the MUL state and shift-add multiplier; otherwise op 0111 is a NOP.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             s,
   output logic             z,
   output logic             c,
   output logic             v,
   output logic             rd_we,
   output logic             szcv_we,
   output logic             in_flag,
   output logic             out_flag,
   output logic             halt_flag
);

   op_t              opc;
   logic             accept, ld, nop, sh_c;
   logic             ov_q, rd_q, sw_q, inf_q, outf_q, hf_q;
   logic             rd_n, sw_n, inf_n, outf_n, hf_n;
   logic [WIDTH-1:0] res_q, res_n, sh_res;
   logic [WIDTH:0]   add_w, sub_w;
   flag_t            flg_q, flg_n;

   assign opc    = op_t'(op);
   assign add_w  = {1'b0, a} + {1'b0, b};
   assign sub_w  = {1'b0, b} - {1'b0, a};
   assign accept = in_valid && in_ready;

   seq_alu_shifter #(.WIDTH(WIDTH)) u_shift (
      .op     (opc),
      .b      (b),
      .d      (d),
      .result (sh_res),
      .carry  (sh_c)
   );

`ifdef SEQ_ALU_MUL_EN
   state_t             state;
   logic [2*WIDTH-1:0] prod, prod_nx;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH:0]     psum;
   logic [SHW-1:0]     cnt;
   logic               mul_done;

   // prod starts as {0, b}; each step adds a into the upper half when the low bit is set, then shifts right.
   assign psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
   assign prod_nx  = {psum, prod[WIDTH-1:1]};
   assign mul_done = (state == MUL) && (cnt == SHW'(WIDTH - 1));
   assign in_ready = (state == IDLE) && (!ov_q || out_ready);
   assign ld       = (accept && opc != OP_MUL) || mul_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         prod  <= '0;
         mcand <= '0;
         cnt   <= '0;
      end else if (state == IDLE) begin
         if (accept && opc == OP_MUL) begin
            state <= MUL;
            prod  <= {{WIDTH{1'b0}}, b};
            mcand <= a;
            cnt   <= '0;
         end
      end else begin
         prod <= prod_nx;
         cnt  <= cnt + 1'b1;
         if (mul_done) state <= IDLE;
      end
   end
`else
   assign in_ready = !ov_q || out_ready;
   assign ld       = accept;
`endif

   always_comb begin
      res_n  = '0;
      flg_n  = '0;
      rd_n   = 1'b1;
      sw_n   = 1'b1;
      inf_n  = 1'b0;
      outf_n = 1'b0;
      hf_n   = 1'b0;
      nop    = 1'b0;
      case (opc)
         OP_ADD: begin
            res_n   = add_w[WIDTH-1:0];
            flg_n.c = add_w[WIDTH];
            flg_n.v = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            res_n   = sub_w[WIDTH-1:0];
            flg_n.c = sub_w[WIDTH];
            flg_n.v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != b[WIDTH-1]);
            rd_n    = opc == OP_SUB;
         end
         OP_AND: res_n = a & b;
         OP_OR:  res_n = a | b;
         OP_XOR: res_n = a ^ b;
         OP_MOV: res_n = a;
         OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
            res_n   = sh_res;
            flg_n.c = sh_c;
         end
         OP_IN: inf_n = 1'b1;
         OP_OUT: begin
            res_n  = a;
            outf_n = 1'b1;
            rd_n   = 1'b0;
            sw_n   = 1'b0;
         end
         OP_HALT: begin
            hf_n = 1'b1;
            rd_n = 1'b0;
            sw_n = 1'b0;
         end
         default: begin
            nop  = 1'b1;
            rd_n = 1'b0;
            sw_n = 1'b0;
         end
      endcase
`ifdef SEQ_ALU_MUL_EN
      if (mul_done) begin
         res_n   = prod_nx[WIDTH-1:0];
         flg_n.c = |prod_nx[2*WIDTH-1:WIDTH];
         flg_n.v = |prod_nx[2*WIDTH-1:WIDTH];
         rd_n    = 1'b1;
         sw_n    = 1'b1;
         inf_n   = 1'b0;
         outf_n  = 1'b0;
         hf_n    = 1'b0;
         nop     = 1'b0;
      end
`endif
      flg_n.s = !nop && res_n[WIDTH-1];
      flg_n.z = !nop && (res_n == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov_q   <= 1'b0;
         res_q  <= '0;
         flg_q  <= '0;
         rd_q   <= 1'b0;
         sw_q   <= 1'b0;
         inf_q  <= 1'b0;
         outf_q <= 1'b0;
         hf_q   <= 1'b0;
      end else if (ld) begin
         ov_q   <= 1'b1;
         res_q  <= res_n;
         flg_q  <= flg_n;
         rd_q   <= rd_n;
         sw_q   <= sw_n;
         inf_q  <= inf_n;
         outf_q <= outf_n;
         hf_q   <= hf_n;
      end else if (out_ready) begin
         ov_q <= 1'b0;
      end
   end

   assign out_valid = ov_q;
   assign result    = res_q;
   assign s         = ov_q && flg_q.s;
   assign z         = ov_q && flg_q.z;
   assign c         = ov_q && flg_q.c;
   assign v         = ov_q && flg_q.v;
   assign rd_we     = ov_q && rd_q;
   assign szcv_we   = ov_q && sw_q;
   assign in_flag   = ov_q && inf_q;
   assign out_flag  = ov_q && outf_q;
   assign halt_flag = ov_q && hf_q;

endmodule
